// File: rtl/johnson_monitor_if.sv
// Johnson monitor bundle: sample inputs (EN, Q, CLR_CNT) and registered status outputs.
// Latency: none (wires only); the monitor drives every status output from a flop.
// Backpressure: none; EN gates sampling, and the monitor can never stall its source.
//
// Signals:
//   EN        sample enable         Q         observed counter, Q[0] = first stage
//   CLR_CNT   sync clear of ERR_CNT IDX       decoded index of last legal sample
//   IDX_VALID last sample legal     LOCKED    tracking a correctly stepping sequence
//   ERR       fault-while-locked    WRAP      locked step from 2N-1 to 0
//   ERR_CNT   saturating ERR count
interface johnson_monitor_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    localparam int IW = $clog2(2 * N);

    logic             EN;
    logic [N-1:0]     Q;
    logic             CLR_CNT;
    logic [IW-1:0]    IDX;
    logic             IDX_VALID;
    logic             LOCKED;
    logic             ERR;
    logic             WRAP;
    logic [CNT_W-1:0] ERR_CNT;

    // Stimulus side: drives the sample inputs and observes status.
    modport master (
        output EN, Q, CLR_CNT,
        input  IDX, IDX_VALID, LOCKED, ERR, WRAP, ERR_CNT
    );

    // Monitor side.
    modport slave (
        input  EN, Q, CLR_CNT,
        output IDX, IDX_VALID, LOCKED, ERR, WRAP, ERR_CNT
    );
endinterface

// File: rtl/johnson_monitor.sv
// Johnson counter monitor: decodes Q, checks for +1 steps, locks and reports faults.
// Latency: 1 edge; a sample taken at edge t is reflected on all outputs right after t.
// Backpressure: none; EN=0 freezes all state and forces the ERR/WRAP pulses low.
//
// Ports:
//   CLK  rising-edge clock
//   CLR  asynchronous active-low reset (the only reset)
//   mon  johnson_monitor_if.slave: EN, Q, CLR_CNT in; IDX, IDX_VALID, LOCKED,
//        ERR, WRAP, ERR_CNT out (all registered)
module johnson_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = 8,
    parameter int IW       = $clog2(2 * N)
) (
    input  logic               CLK,
    input  logic               CLR,
    johnson_monitor_if.slave   mon
);

    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);
    localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Registered state
    state_t           state_q,   state_d;
    logic [3:0]       step_cnt_q, step_cnt_d;
    logic [IW-1:0]    prev_q,    prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [IW-1:0]    idx_q,     idx_d;
    logic             idx_vld_q, idx_vld_d;
    logic             err_q,     err_d;
    logic             wrap_q,    wrap_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Decode / classification
    logic             legal;
    logic [IW-1:0]    dec_idx;
    logic [N-1:0]     pat;
    logic [IW-1:0]    prev_next;
    logic             is_step;
    logic             is_hold;
    logic             is_fault;
    logic             wrap_cand;
    logic [3:0]       step_inc;
    logic [CNT_W-1:0] err_cnt_sat;

    // Decoder: compare Q against each of the 2N legal patterns.
    // Index i <= N: the low i stages are ones (fill phase).
    // Index N+k:    the low k stages are zeros, rest ones (drain phase).
    always_comb begin
        legal   = 1'b0;
        dec_idx = '0;
        pat     = '0;
        for (int i = 0; i < 2 * N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i <= N) begin
                    pat[j] = (j < i);
                end else begin
                    pat[j] = (j >= i - N);
                end
            end
            if (mon.Q == pat) begin
                legal   = 1'b1;
                dec_idx = IW'(i);
            end
        end
    end

    assign prev_next   = (prev_q == LAST_IDX) ? '0 : prev_q + 1'b1;
    assign step_inc    = step_cnt_q + 4'd1;
    assign err_cnt_sat = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q : err_cnt_q + 1'b1;

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        idx_d      = idx_q;
        idx_vld_d  = idx_vld_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        is_step    = 1'b0;
        is_hold    = 1'b0;
        is_fault   = 1'b0;
        wrap_cand  = 1'b0;

        if (mon.EN) begin
            if (legal) begin
                idx_d      = dec_idx;
                idx_vld_d  = 1'b1;
                prev_d     = dec_idx;
                prev_vld_d = 1'b1;
                // Without a valid previous index the sample only seeds it.
                if (prev_vld_q) begin
                    if (dec_idx == prev_q) begin
                        is_hold = 1'b1;
                    end else if (dec_idx == prev_next) begin
                        is_step = 1'b1;
                    end else begin
                        is_fault = 1'b1;
                    end
                end
            end else begin
                // Illegal code: IDX keeps the last legal value, history is dropped.
                idx_vld_d  = 1'b0;
                prev_vld_d = 1'b0;
                is_fault   = 1'b1;
            end

            wrap_cand = is_step && (prev_q == LAST_IDX);

            case (state_q)
                ST_SEARCH: begin
                    if (is_step) begin
                        if (step_inc == LOCK_TGT) begin
                            // The locking step itself may wrap and is reported.
                            state_d    = ST_LOCKED;
                            step_cnt_d = '0;
                            wrap_d     = wrap_cand;
                        end else begin
                            step_cnt_d = step_inc;
                        end
                    end else if (is_fault) begin
                        step_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_step) begin
                        wrap_d = wrap_cand;
                    end else if (is_fault) begin
                        err_d      = 1'b1;
                        err_cnt_d  = err_cnt_sat;
                        state_d    = ST_SEARCH;
                        step_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_SEARCH;
                    step_cnt_d = '0;
                end
            endcase
        end

        // Clear beats a same-edge increment and ignores EN.
        if (mon.CLR_CNT) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q    <= ST_SEARCH;
            step_cnt_q <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            idx_q      <= '0;
            idx_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            idx_q      <= idx_d;
            idx_vld_q  <= idx_vld_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign mon.IDX       = idx_q;
    assign mon.IDX_VALID = idx_vld_q;
    assign mon.LOCKED    = (state_q == ST_LOCKED);
    assign mon.ERR       = err_q;
    assign mon.WRAP      = wrap_q;
    assign mon.ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// Testbench for johnson_monitor (N=4, LOCK_CNT=2, CNT_W=8).
// Each scenario task pushes expected output vectors into a scoreboard queue as it
// drives a sample, then pops and compares once the DUT has registered the result.
module tb_johnson_monitor;

    typedef struct packed {
        logic [2:0] idx;
        logic       vld;
        logic       lk;
        logic       err;
        logic       wrap;
        logic [7:0] cnt;
    } out_t;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;
    out_t sb[$];

    johnson_monitor_if #(.N(4), .CNT_W(8)) mon ();

    johnson_monitor #(.N(4), .LOCK_CNT(2), .CNT_W(8)) dut (
        .CLK (clk),
        .CLR (clr),
        .mon (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    function automatic out_t mk(input int idx, input bit v, input bit l,
                                input bit e, input bit w, input int c);
        out_t r;
        r.idx  = 3'(idx);
        r.vld  = v;
        r.lk   = l;
        r.err  = e;
        r.wrap = w;
        r.cnt  = 8'(c);
        return r;
    endfunction

    function automatic out_t observe();
        out_t r;
        r.idx  = mon.IDX;
        r.vld  = mon.IDX_VALID;
        r.lk   = mon.LOCKED;
        r.err  = mon.ERR;
        r.wrap = mon.WRAP;
        r.cnt  = mon.ERR_CNT;
        return r;
    endfunction

    // s is written Q1Q2Q3Q4 (s[3] = Q1 = Q[0]).
    function automatic logic [3:0] q_of(input logic [3:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

    // Push the expectation, apply one sample, settle just after the edge.
    task automatic drive(input logic en, input logic [3:0] s, input logic cc, input out_t e);
        sb.push_back(e);
        mon.EN      = en;
        mon.Q       = q_of(s);
        mon.CLR_CNT = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t got, ex;
        clr         = 1'b0;
        mon.EN      = 1'b1;
        mon.Q       = '0;
        mon.CLR_CNT = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b0000, 1'b0, mk(0, 0, 0, 0, 0, 0));
            got = observe();
            ex  = sb.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, got, ex);
            end
        end
        #2 clr = 1'b1;
    endtask

    task automatic test_lock();
        logic [3:0] sq [3];
        out_t ex_t [3];
        out_t got, ex;
        sq   = '{4'b0000, 4'b1000, 4'b1100};
        ex_t = '{mk(0, 1, 0, 0, 0, 0), mk(1, 1, 0, 0, 0, 0), mk(2, 1, 1, 0, 0, 0)};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sq[i], 1'b0, ex_t[i]);
            got = observe();
            ex  = sb.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL lock[%0d] got=%h exp=%h", i, got, ex);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] sq [7];
        int         ix [7];
        out_t got, ex;
        sq = '{4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
        ix = '{3, 4, 5, 6, 7, 0, 1};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, sq[i], 1'b0, mk(ix[i], 1, 1, 0, (i == 5), 0));
            got = observe();
            ex  = sb.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL wrap[%0d] got=%h exp=%h", i, got, ex);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] sq [5];
        out_t ex_t [5];
        out_t got, ex;
        sq   = '{4'b1100, 4'b1010, 4'b1100, 4'b1110, 4'b1111};
        ex_t = '{mk(2, 1, 1, 0, 0, 0), mk(2, 0, 0, 1, 0, 1), mk(2, 1, 0, 0, 0, 1),
                 mk(3, 1, 0, 0, 0, 1), mk(4, 1, 1, 0, 0, 1)};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, sq[i], 1'b0, ex_t[i]);
            got = observe();
            ex  = sb.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL illegal[%0d] got=%h exp=%h", i, got, ex);
            end
        end
    endtask

    task automatic test_skip_hold_en();
        logic [3:0] sq [15];
        logic       en [15];
        out_t ex_t [15];
        out_t got, ex;
        sq   = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1111,
                 4'b1000, 4'b1100, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b0101, 4'b0101};
        en   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        ex_t = '{mk(5, 1, 1, 0, 0, 1), mk(6, 1, 1, 0, 0, 1), mk(7, 1, 1, 0, 0, 1),
                 mk(0, 1, 1, 0, 1, 1), mk(1, 1, 1, 0, 0, 1), mk(2, 1, 1, 0, 0, 1),
                 mk(4, 1, 0, 1, 0, 2), mk(1, 1, 0, 0, 0, 2), mk(2, 1, 0, 0, 0, 2),
                 mk(3, 1, 1, 0, 0, 2), mk(3, 1, 1, 0, 0, 2), mk(3, 1, 1, 0, 0, 2),
                 mk(3, 1, 1, 0, 0, 2), mk(3, 1, 1, 0, 0, 2), mk(3, 1, 1, 0, 0, 2)};
        for (int i = 0; i < 15; i++) begin
            drive(en[i], sq[i], 1'b0, ex_t[i]);
            got = observe();
            ex  = sb.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL skip_hold_en[%0d] got=%h exp=%h", i, got, ex);
            end
        end
    endtask

    task automatic test_saturate_clear();
        out_t got, ex;
        int   c;
        // Each round: locked fault, then seed + two steps to relock at index 2.
        for (int f = 0; f < 260; f++) begin
            c = (3 + f > 255) ? 255 : 3 + f;
            for (int r = 0; r < 4; r++) begin
                case (r)
                    0:       drive(1'b1, 4'b1010, 1'b0, mk((f == 0) ? 3 : 2, 0, 0, 1, 0, c));
                    1:       drive(1'b1, 4'b0000, 1'b0, mk(0, 1, 0, 0, 0, c));
                    2:       drive(1'b1, 4'b1000, 1'b0, mk(1, 1, 0, 0, 0, c));
                    default: drive(1'b1, 4'b1100, 1'b0, mk(2, 1, 1, 0, 0, c));
                endcase
                got = observe();
                ex  = sb.pop_front();
                n_checks++;
                if (got !== ex) begin
                    n_fail++;
                    $display("FAIL sat[%0d.%0d] got=%h exp=%h", f, r, got, ex);
                end
            end
        end
        // Clear on the same edge as a fault; relock; fault; clear with EN=0; relock.
        for (int r = 0; r < 9; r++) begin
            case (r)
                0: drive(1'b1, 4'b1010, 1'b1, mk(2, 0, 0, 1, 0, 0));
                1: drive(1'b1, 4'b0000, 1'b0, mk(0, 1, 0, 0, 0, 0));
                2: drive(1'b1, 4'b1000, 1'b0, mk(1, 1, 0, 0, 0, 0));
                3: drive(1'b1, 4'b1100, 1'b0, mk(2, 1, 1, 0, 0, 0));
                4: drive(1'b1, 4'b1010, 1'b0, mk(2, 0, 0, 1, 0, 1));
                5: drive(1'b0, 4'b0000, 1'b1, mk(2, 0, 0, 0, 0, 0));
                6: drive(1'b1, 4'b0000, 1'b0, mk(0, 1, 0, 0, 0, 0));
                7: drive(1'b1, 4'b1000, 1'b0, mk(1, 1, 0, 0, 0, 0));
                default: drive(1'b1, 4'b1100, 1'b0, mk(2, 1, 1, 0, 0, 0));
            endcase
            got = observe();
            ex  = sb.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL clr_cnt[%0d] got=%h exp=%h", r, got, ex);
            end
        end
    endtask

    task automatic test_async_reset();
        out_t got, ex;
        // Mid-cycle assertion while locked: outputs must clear before any edge.
        #3;
        clr = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        #1;
        got = observe();
        ex  = sb.pop_front();
        n_checks++;
        if (got !== ex) begin
            n_fail++;
            $display("FAIL async_reset_now got=%h exp=%h", got, ex);
        end
        for (int r = 0; r < 5; r++) begin
            case (r)
                0: drive(1'b1, 4'b1110, 1'b0, mk(0, 0, 0, 0, 0, 0));
                1: begin
                    #4 clr = 1'b1;
                    drive(1'b1, 4'b0011, 1'b0, mk(6, 1, 0, 0, 0, 0));
                end
                2: drive(1'b1, 4'b0001, 1'b0, mk(7, 1, 0, 0, 0, 0));
                3: drive(1'b1, 4'b0000, 1'b0, mk(0, 1, 1, 0, 1, 0));
                default: drive(1'b1, 4'b1000, 1'b0, mk(1, 1, 1, 0, 0, 0));
            endcase
            got = observe();
            ex  = sb.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL async_relock[%0d] got=%h exp=%h", r, got, ex);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_lock();
        test_wrap();
        test_illegal();
        test_skip_hold_en();
        test_saturate_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_monitor.md
JOHNSON_MONITOR -- requirements
Module: johnson_monitor

Interface
REQ-001: Parameter N, default 4, number of Johnson stages; legal codes = 2N; SHALL be >= 2.
REQ-002: Parameter LOCK_CNT, default 2, consecutive correct steps required to lock; SHALL be 1..15.
REQ-003: Parameter CNT_W, default 8, ERR_CNT width.
REQ-004: Parameter IW = clog2(2N), derived, IDX width (N=4 -> 3).
REQ-005: CLK  input  1  single clock; all state updates on rising edge.
REQ-006: CLR  input  1  reset, asynchronous assert, active-low; no other reset exists.
REQ-007: EN  input  1  sample enable; Q is sampled only on edges with EN=1.
REQ-008: Q  input  N  observed Johnson counter state; Q[0] = first stage (Q1), Q[N-1] = last stage.
REQ-009: CLR_CNT  input  1  synchronous clear of ERR_CNT.
REQ-010: IDX  output  IW  decoded count index of last legal sample.
REQ-011: IDX_VALID  output  1  last sample was a legal code.
REQ-012: LOCKED  output  1  monitor is tracking a correctly stepping sequence.
REQ-013: ERR  output  1  one-cycle pulse: fault detected while LOCKED.
REQ-014: WRAP  output  1  one-cycle pulse: locked step from index 2N-1 to 0.
REQ-015: ERR_CNT  output  CNT_W  saturating count of ERR pulses.

Function
REQ-016: Decode SHALL be: index k (0..N) = Q[k-1:0] all ones, rest zeros; index N+k (k=1..N-1) = Q[k-1:0] all zeros, rest ones; any other pattern is illegal (N=4: 0000,1000,1100,1110,1111,0111,0011,0001 -> 0..7, written Q1Q2Q3Q4).
REQ-017: All outputs SHALL be registered; results of a sample taken at edge t appear immediately after edge t (latency 1 edge).
REQ-018: Per EN=1 sample, classification vs. stored previous index P (if P valid): HOLD = same index; STEP = (P+1) mod 2N; SKIP = other legal index; ILLEGAL = illegal code.
REQ-019: Legal sample SHALL set IDX to decoded index, IDX_VALID=1, store P; ILLEGAL SHALL set IDX_VALID=0, hold IDX, and invalidate P.
REQ-020: First legal sample with P invalid SHALL seed P only; no step counted, no fault.
REQ-021: FSM states SEARCH (reset) and LOCKED; LOCKED output = (state==LOCKED).
REQ-022: SEARCH: STEP increments step counter; HOLD leaves it; SKIP or ILLEGAL clears it; on reaching LOCK_CNT go to LOCKED and clear counter.
REQ-023: LOCKED: STEP or HOLD stays; SKIP or ILLEGAL SHALL pulse ERR, increment ERR_CNT, go to SEARCH with counter 0.
REQ-024: Faults in SEARCH SHALL NOT assert ERR or change ERR_CNT.
REQ-025: WRAP SHALL pulse only for a STEP from 2N-1 to 0 classified while LOCKED (including the step that causes lock).
REQ-026: ERR_CNT SHALL saturate at all ones; CLR_CNT=1 SHALL force 0 and wins over a simultaneous increment; CLR_CNT acts regardless of EN.
REQ-027: EN=0: no state, P, IDX or counter change; ERR and WRAP = 0.

Reset
REQ-028: CLR=0 SHALL immediately force IDX=0, IDX_VALID=0, LOCKED=0 (SEARCH), ERR=0, WRAP=0, ERR_CNT=0, step counter 0, P invalid; holds while CLR=0, including mid-lock.
REQ-029: First sample occurs on first rising edge with CLR=1 and EN=1.

Verification (N=4, LOCK_CNT=2)
REQ-030: Reset, EN=1, Q=0000,1000,1100 -> IDX 0,1,2, IDX_VALID=1; LOCKED=1 after third edge, not before.
REQ-031: Locked, feed 1111,0111,0011,0001,0000 -> IDX 4..7,0; WRAP=1 exactly one cycle with IDX=0; ERR=0.
REQ-032: Locked at IDX=2, Q=1010 -> ERR one cycle, ERR_CNT=1, LOCKED=0, IDX_VALID=0, IDX=2; then 1100,1110,1111 -> relock after 1111 (seed, two steps).
REQ-033: Locked at 1100, Q=1111 (SKIP) -> ERR, ERR_CNT+1, LOCKED=0, IDX=4, IDX_VALID=1; 1110 repeated 3x while locked -> no ERR; EN=0 with Q=0101 -> no output change.
REQ-034: Force 260 locked faults -> ERR_CNT stays 255; CLR_CNT=1 on same edge as a fault -> ERR_CNT=0, ERR=1.
REQ-035: CLR pulsed low between edges while LOCKED -> all outputs reset at once, without waiting for an edge; relock requires seed + 2 steps.
